// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and requester ids for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_RADDR_W = 4;
  localparam logic REQ_ALU   = 1'b0;
  localparam logic REQ_LSU   = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Elastic circular-buffer FIFO for one writeback requester.
// With REGFILE_WB_PENDING_EN defined, also exposes per-entry rd and valid bits.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
`ifdef REGFILE_WB_PENDING_EN
  , parameter int RD_W = 4
`endif
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
`ifdef REGFILE_WB_PENDING_EN
  , output logic [DEPTH-1:0][RD_W-1:0] o_ent_rd
  , output logic [DEPTH-1:0]           o_ent_vld
`endif
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PTR_W-1:0]        r_wptr, r_rptr;
  logic [PTR_W:0]          r_cnt;
  logic                    w_push, w_pop;

  assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (PTR_W+1)'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

`ifdef REGFILE_WB_PENDING_EN
  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    o_ent_rd  = '0;
    o_ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_ent_rd[i]  = r_mem[i][W-1 -: RD_W];
      o_ent_vld[i] = ({1'b0, PTR_W'(i) - r_rptr}) < r_cnt;
    end
  end
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port between ALU (0) and LSU (1).
// Optional REGFILE_WB_PENDING_EN adds O_pending, the per-register in-flight write mask.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int XLEN    = DEF_XLEN,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_req0_valid,
  output logic               O_req0_ready,
  input  logic [RADDR_W-1:0] I_req0_rd,
  input  logic [XLEN-1:0]    I_req0_data,
  input  logic               I_req1_valid,
  output logic               O_req1_ready,
  input  logic [RADDR_W-1:0] I_req1_rd,
  input  logic [XLEN-1:0]    I_req1_data,
  input  logic               I_hold,
  output logic               O_regwen,
  output logic [RADDR_W-1:0] O_rd,
  output logic [XLEN-1:0]    O_data,
`ifdef REGFILE_WB_PENDING_EN
  output logic [15:0]        O_pending,
`endif
  output logic               O_idle
);
  localparam int W = RADDR_W + XLEN;

  logic [1:0]         w_push, w_pop, w_full, w_empty;
  logic [1:0][W-1:0]  w_din, w_dout;
  logic               w_gnt1;
  logic               r_regwen, r_last;
  logic [RADDR_W-1:0] r_rd;
  logic [XLEN-1:0]    r_data;
`ifdef REGFILE_WB_PENDING_EN
  logic [1:0][DEPTH-1:0][RADDR_W-1:0] w_ent_rd;
  logic [1:0][DEPTH-1:0]              w_ent_vld;
  logic [15:0]                        w_pend;
`endif

  assign w_din[0] = {I_req0_rd, I_req0_data};
  assign w_din[1] = {I_req1_rd, I_req1_data};
  // Writes to x0 complete the handshake but never occupy a slot.
  assign w_push[0] = I_req0_valid && !w_full[0] && (I_req0_rd != '0);
  assign w_push[1] = I_req1_valid && !w_full[1] && (I_req1_rd != '0);
  assign O_req0_ready = ~w_full[0];
  assign O_req1_ready = ~w_full[1];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    wb_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
`ifdef REGFILE_WB_PENDING_EN
      , .RD_W(RADDR_W)
`endif
    ) u_fifo (
      .i_clk   (I_clk),
      .i_rst_n (I_rst_n),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_din   (w_din[g]),
      .o_dout  (w_dout[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
`ifdef REGFILE_WB_PENDING_EN
      , .o_ent_rd (w_ent_rd[g])
      , .o_ent_vld(w_ent_vld[g])
`endif
    );
  end

  // Requester 1 wins when it is the only one waiting, or when 0 was served last.
  assign w_gnt1   = !w_empty[1] && (w_empty[0] || r_last == REQ_ALU);
  assign w_pop[1] = !I_hold && w_gnt1;
  assign w_pop[0] = !I_hold && !w_empty[0] && !w_gnt1;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_regwen <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_last   <= REQ_LSU;
    end else begin
      r_regwen <= |w_pop;
      if (|w_pop) begin
        {r_rd, r_data} <= w_pop[1] ? w_dout[1] : w_dout[0];
        r_last         <= w_pop[1] ? REQ_LSU : REQ_ALU;
      end
    end
  end

  assign O_regwen = r_regwen;
  assign O_rd     = r_rd;
  assign O_data   = r_data;
  assign O_idle   = ~r_regwen && w_empty[0] && w_empty[1];

`ifdef REGFILE_WB_PENDING_EN
  always_comb begin
    w_pend = '0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < DEPTH; i++)
        if (w_ent_vld[r][i]) w_pend[w_ent_rd[r][i]] = 1'b1;
    if (r_regwen) w_pend[r_rd] = 1'b1;
    w_pend[0] = 1'b0;
  end
  assign O_pending = w_pend;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: queue-based reference model plus directed cases.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, hold = 1'b0;
  logic [3:0]  rd0 = '0, rd1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        rdy0, rdy1, regwen, idle;
  logic [3:0]  o_rd;
  logic [31:0] o_data;
`ifdef REGFILE_WB_PENDING_EN
  logic [15:0] pending;
`endif

  int n_chk = 0, n_pass = 0;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(32), .RADDR_W(4)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_req0_valid(v0), .O_req0_ready(rdy0), .I_req0_rd(rd0), .I_req0_data(d0),
    .I_req1_valid(v1), .O_req1_ready(rdy1), .I_req1_rd(rd1), .I_req1_data(d1),
    .I_hold(hold), .O_regwen(regwen), .O_rd(o_rd), .O_data(o_data),
`ifdef REGFILE_WB_PENDING_EN
    .O_pending(pending),
`endif
    .O_idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: two queues, a last-winner flag and the write stage.
  typedef struct packed {logic [3:0] rd; logic [31:0] d;} ent_t;
  ent_t        q0[$], q1[$];
  logic        m_wen = 1'b0;
  logic [3:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  int          m_last = 1;

  function automatic logic [15:0] m_pend();
    logic [15:0] p = '0;
    foreach (q0[i]) p[q0[i].rd] = 1'b1;
    foreach (q1[i]) p[q1[i].rd] = 1'b1;
    if (m_wen) p[m_rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic m_conflict();
    foreach (q0[i]) foreach (q1[j]) if (q0[i].rd == q1[j].rd) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int s0, s1, g;
    ent_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q0.delete(); q1.delete();
        m_wen = 1'b0; m_rd = '0; m_data = '0; m_last = 1;
      end else begin
        s0 = q0.size(); s1 = q1.size(); g = -1;
        if (!hold) begin
          if (s0 > 0 && s1 > 0) g = 1 - m_last;
          else if (s0 > 0)      g = 0;
          else if (s1 > 0)      g = 1;
        end
        m_wen = (g >= 0);
        if (g == 0) begin e = q0.pop_front(); m_rd = e.rd; m_data = e.d; m_last = 0; end
        if (g == 1) begin e = q1.pop_front(); m_rd = e.rd; m_data = e.d; m_last = 1; end
        if (v0 && s0 < DEPTH && rd0 != 0) q0.push_back({rd0, d0});
        if (v1 && s1 < DEPTH && rd1 != 0) q1.push_back({rd1, d1});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("regwen", regwen, m_wen);
        chk("rd", o_rd, m_rd);
        chk("data", o_data, m_data);
        chk("idle", idle, !m_wen && q0.size() == 0 && q1.size() == 0);
        chk("ready0", rdy0, q0.size() < DEPTH);
        chk("ready1", rdy1, q1.size() < DEPTH);
        chk("same_rd_both_queues", m_conflict(), 1'b0);
`ifdef REGFILE_WB_PENDING_EN
        chk("pending", pending, m_pend());
`endif
      end
    end
  end

  task automatic send(input int r, input logic [3:0] rd, input logic [31:0] d);
    logic acc = 1'b0;
    @(negedge clk);
    if (r == 0) begin v0 = 1'b1; rd0 = rd; d0 = d; end
    else        begin v1 = 1'b1; rd1 = rd; d1 = d; end
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = (r == 0) ? rdy0 : rdy1;
      @(negedge clk);
    end
    if (r == 0) v0 = 1'b0; else v1 = 1'b0;
    chk("send_accept", acc, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  i0, i1;
    logic a0, a1, acc;
    // Reset values
    #12;
    chk("rst_regwen", regwen, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_data", o_data, 0);
    chk("rst_idle", idle, 1);
    @(negedge clk); #2 rst_n = 1'b1;

    // Contention right after reset: requester 0 first
    @(negedge clk);
    v0 = 1; rd0 = 4'd1; d0 = 32'hAAAA_0001;
    v1 = 1; rd1 = 4'd2; d1 = 32'hBBBB_0002;
    @(negedge clk); v0 = 0; v1 = 0;
    @(negedge clk);
    chk("cont_first_rd", o_rd, 4'd1);
    chk("cont_first_data", o_data, 32'hAAAA_0001);
    @(negedge clk);
    chk("cont_second_rd", o_rd, 4'd2);
    chk("cont_second_wen", regwen, 1);
    @(negedge clk);
    chk("cont_done_idle", idle, 1);

    // Single write latency
    send(0, 4'd5, 32'hDEADBEEF);
    chk("single_wen_T1", regwen, 0);
    chk("single_busy", idle, 0);
    @(negedge clk);
    chk("single_wen", regwen, 1);
    chk("single_rd", o_rd, 4'd5);
    chk("single_data", o_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_one_cycle", regwen, 0);
    chk("single_idle", idle, 1);

    // Sustained dual streams
    i0 = 0; i1 = 0;
    for (int c = 0; c < 200 && (i0 < 8 || i1 < 8); c++) begin
      @(negedge clk);
      v0 = (i0 < 8); rd0 = 4'(1 + i0);      d0 = 32'h1000 + i0;
      v1 = (i1 < 8); rd1 = 4'(9 + (i1 % 7)); d1 = 32'h2000 + i1;
      a0 = v0 && rdy0; a1 = v1 && rdy1;
      @(posedge clk);
      if (a0) i0++;
      if (a1) i1++;
    end
    @(negedge clk); v0 = 0; v1 = 0;
    chk("streams_all_accepted", i0 + i1, 16);
    repeat (8) @(negedge clk);
    chk("streams_drained", idle, 1);

    // Backpressure under hold
    hold = 1;
    send(1, 4'd3, 32'hC0C0_0003);
    send(1, 4'd4, 32'hC0C0_0004);
    chk("bp_full_ready", rdy1, 0);
    v1 = 1; rd1 = 4'd5; d1 = 32'hC0C0_0005;
    @(negedge clk); @(negedge clk);
    chk("bp_still_full", rdy1, 0);
    chk("bp_hold_no_wen", regwen, 0);
    hold = 0;
    @(negedge clk);
    chk("bp_first_rd", o_rd, 4'd3);
    chk("bp_ready_back", rdy1, 1);
    @(negedge clk); v1 = 0;
    chk("bp_second_rd", o_rd, 4'd4);
    @(negedge clk);
    chk("bp_third_rd", o_rd, 4'd5);
    chk("bp_third_wen", regwen, 1);
    repeat (2) @(negedge clk);

    // Write to x0 is swallowed
    send(0, 4'd0, 32'hFFFF_FFFF);
    chk("x0_no_wen", regwen, 0);
    chk("x0_idle", idle, 1);
    @(negedge clk);
    chk("x0_no_wen_later", regwen, 0);
    chk("x0_rd_held", o_rd, 4'd5);

`ifdef REGFILE_WB_PENDING_EN
    hold = 1;
    send(1, 4'd7, 32'h7777_7777);
    chk("pend_bit7_queued", pending[7], 1);
    chk("pend_bit0", pending[0], 0);
    hold = 0;
    @(negedge clk);
    chk("pend_bit7_wstage", pending[7], 1);
    chk("pend_wen", regwen, 1);
    @(negedge clk);
    chk("pend_bit7_clear", pending[7], 0);
`endif

    // Asynchronous reset mid-operation
    hold = 1;
    send(0, 4'd6, 32'h6666_6666);
    send(1, 4'd9, 32'h9999_9999);
    hold = 0;
    @(posedge clk); #1;
    chk("arst_pre_wen", regwen, 1);
    chk("arst_pre_busy", idle, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wen_now", regwen, 0);
    chk("arst_rd_now", o_rd, 0);
    chk("arst_idle_now", idle, 1);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_no_stale", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
